// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 8-bit registered ALU with a 3-bit opcode.
//
// One operation is accepted every clock; result and zero appear one cycle
// after the operands are sampled and hold until the next rising edge.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset (clears result and zero)
//   instruction  opcode: 000 XOR, 001 BEQ, 010 ADD, 011 AND, 100 RSL,
//                101..111 reserved (result 8'hFF)
//   input1       operand A
//   input2       operand B (low 3 bits are the RSL rotate amount)
//   result       registered operation result
//   zero         registered equality flag, driven only by BEQ
// ---------------------------------------------------------------------------
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] instruction,
  input  logic [7:0] input1,
  input  logic [7:0] input2,
  output logic [7:0] result,
  output logic       zero
);

  typedef enum logic [2:0] {
    OP_XOR  = 3'b000,
    OP_BEQ  = 3'b001,
    OP_ADD  = 3'b010,
    OP_AND  = 3'b011,
    OP_RSL  = 3'b100
  } opcode_e;

  logic [7:0]  result_q, result_d;
  logic        zero_q, zero_d;
  logic [15:0] rot_wide;

  // Rotate by shifting a doubled copy of input1; the upper byte then holds
  // the bits that wrapped out of bit 7 back in at bit 0.
  assign rot_wide = {input1, input1} << input2[2:0];

  // Next-state decode. Every opcode is covered; reserved codes fall into the
  // default branch and produce all ones.
  always_comb begin
    result_d = 8'hFF;
    zero_d   = 1'b0;
    case (opcode_e'(instruction))
      OP_XOR: result_d = input1 ^ input2;
      OP_BEQ: begin
        result_d = input1 - input2;
        zero_d   = (input1 == input2);
      end
      OP_ADD: result_d = input1 + input2;
      OP_AND: result_d = input1 & input2;
      OP_RSL: result_d = rot_wide[15:8];
      default: begin
        result_d = 8'hFF;
        zero_d   = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears them immediately without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 8'h00;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for the 8-bit registered ALU.
//
// Directed vectors for each opcode and the reset behaviour are followed by a
// run of random operations, all compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [2:0] instruction;
  logic [7:0] input1;
  logic [7:0] input2;
  logic [7:0] result;
  logic       zero;

  int checkCount;
  int failCount;

  alu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .input1      (input1),
    .input2      (input2),
    .result      (result),
    .zero        (zero)
  );

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and logs misses.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Behavioural reference: the arithmetic meaning of each opcode.
  function automatic void modelAlu(input logic [2:0] op, input logic [7:0] a,
                                   input logic [7:0] b,
                                   output logic [7:0] res, output logic z);
    int amount;
    res = 8'hFF;
    z   = 1'b0;
    case (op)
      3'd0: res = a ^ b;
      3'd1: begin
        res = 8'((int'(a) - int'(b) + 256) % 256);
        z   = (int'(a) == int'(b));
      end
      3'd2: res = 8'((int'(a) + int'(b)) % 256);
      3'd3: res = a & b;
      3'd4: begin
        amount = int'(b) % 8;
        for (int i = 0; i < 8; i++) res[(i + amount) % 8] = a[i];
      end
      default: res = 8'hFF;
    endcase
  endfunction

  // Drives one operation between edges, then checks the registered output
  // just after the edge and again after the inputs are scrambled.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [7:0] a, input logic [7:0] b);
    logic [7:0] expRes;
    logic       expZero;
    modelAlu(op, a, b, expRes, expZero);
    @(negedge clk);
    instruction = op;
    input1      = a;
    input2      = b;
    @(posedge clk);
    #1;
    checkOutput({tag, ".result"}, result, expRes);
    checkOutput({tag, ".zero"}, {7'd0, zero}, {7'd0, expZero});
    // Outputs must hold while inputs move between edges.
    instruction = 3'(~op);
    input1      = ~a;
    input2      = ~b;
    #2;
    checkOutput({tag, ".hold"}, result, expRes);
  endtask

  initial begin
    int timeoutCycles;
    logic [7:0] rslExp [8];
    logic [2:0] rop;
    logic [7:0] ra, rb;

    checkCount  = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    instruction = 3'd0;
    input1      = 8'h00;
    input2      = 8'h00;

    // Reset state before any edge
    #2;
    checkOutput("reset.result", result, 8'h00);
    checkOutput("reset.zero", {7'd0, zero}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetHeld.result", result, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    applyStimulus("xor", 3'b000, 8'hAA, 8'h55);
    checkOutput("xorConst", result, 8'hFF);
    applyStimulus("beqNe", 3'b001, 8'hAA, 8'h55);
    checkOutput("beqNeConst", result, 8'h55);
    applyStimulus("beqEq", 3'b001, 8'hFF, 8'hFF);
    checkOutput("beqEqZero", {7'd0, zero}, 8'h01);
    applyStimulus("add1", 3'b010, 8'h01, 8'h01);
    checkOutput("add1Const", result, 8'h02);
    applyStimulus("addWrap", 3'b010, 8'hFF, 8'h02);
    checkOutput("addWrapConst", result, 8'h01);
    applyStimulus("and1", 3'b011, 8'h27, 8'h01);
    applyStimulus("and0", 3'b011, 8'h26, 8'h01);
    checkOutput("and0Zero", {7'd0, zero}, 8'h00);

    rslExp = '{8'h91, 8'h23, 8'h46, 8'h8C, 8'h19, 8'h32, 8'h64, 8'hC8};
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("rsl%0d", i), 3'b100, 8'h91, 8'(i));
      checkOutput($sformatf("rslConst%0d", i), result, rslExp[i]);
    end
    applyStimulus("rslUpper", 3'b100, 8'h91, 8'h08);
    checkOutput("rslUpperConst", result, 8'h91);

    for (int op = 5; op < 8; op++) begin
      applyStimulus($sformatf("rsv%0d", op), 3'(op), 8'h91, 8'h00);
      checkOutput($sformatf("rsvConst%0d", op), result, 8'hFF);
    end

    // Asynchronous reset between edges clears outputs at once
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRst.result", result, 8'h00);
    checkOutput("asyncRst.zero", {7'd0, zero}, 8'h00);

    // Pending operation is discarded; first edge after release uses live inputs
    instruction = 3'b010;
    input1      = 8'h10;
    input2      = 8'h20;
    @(posedge clk);
    #1;
    checkOutput("rstDiscard", result, 8'h00);
    @(negedge clk);
    rst_n       = 1'b1;
    instruction = 3'b001;
    input1      = 8'h42;
    input2      = 8'h42;
    @(posedge clk);
    #1;
    checkOutput("postRst.result", result, 8'h00);
    checkOutput("postRst.zero", {7'd0, zero}, 8'h01);

    // Random operations against the model
    for (int n = 0; n < 300; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = (($urandom % 4) == 0) ? ra : 8'($urandom);
      applyStimulus($sformatf("rnd%0d", n), rop, ra, rb);
    end

    timeoutCycles = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    failCount++;
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 8 bits, opcode width at 3 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instruction  input  3  opcode selecting the operation.
REQ-005 input1  input  8  operand A.
REQ-006 input2  input  8  operand B; low 3 bits give the rotate amount for RSL.
REQ-007 result  output  8  registered operation result.
REQ-008 zero  output  1  registered equality flag, asserted only by BEQ.

Function
REQ-009 Every rising clk edge with rst_n high SHALL sample instruction/input1/input2 and load result and zero; latency exactly 1 cycle; no handshake; a new operation every cycle.
REQ-010 Between edges, result and zero SHALL hold their last registered values regardless of input changes.
REQ-011 000 XOR: result = input1 ^ input2; zero = 0.
REQ-012 001 BEQ: result = (input1 - input2) mod 256; zero = 1 iff input1 == input2, else 0.
REQ-013 010 ADD: result = (input1 + input2) mod 256, two's-complement wrap, carry discarded; zero = 0.
REQ-014 011 AND: result = input1 & input2; zero = 0 even when result is 0x00.
REQ-015 100 RSL: result = input1 rotated left by input2[2:0] bit positions (bits leaving bit 7 re-enter at bit 0); input2[7:3] ignored; amount 0 returns input1 unchanged; zero = 0.
REQ-016 101, 110, 111 (reserved): result = 8'hFF; zero = 0.
REQ-017 zero SHALL be 0 for every opcode other than 001; it is not a result==0 detector.
REQ-018 Operands and opcode SHALL be treated as unsigned bit vectors; no flags beyond zero are produced.
REQ-019 Inputs containing X/Z need not produce defined outputs; all 8 opcodes SHALL be fully decoded (no latches, default branch covers reserved codes).

Reset
REQ-020 While rst_n is low, result SHALL be 8'h00 and zero SHALL be 0, asserted asynchronously without waiting for clk.
REQ-021 Reset asserted mid-stream SHALL discard the pending operation; the first rising edge after rst_n deasserts computes from the inputs present at that edge.
REQ-022 rst_n deassertion is assumed synchronous to clk by the system; no internal synchronizer is required.

Verification
REQ-023 XOR: in1=0xAA, in2=0x55, op=000 -> after one edge result=0xFF, zero=0.
REQ-024 BEQ: in1=0xAA, in2=0x55 -> zero=0, result=0x55; then in1=in2=0xFF -> zero=1, result=0x00.
REQ-025 ADD: 0x01+0x01 -> result=0x02, zero=0; 0xFF+0x02 -> result=0x01, zero=0.
REQ-026 AND: 0x27&0x01 -> result=0x01; 0x26&0x01 -> result=0x00 with zero=0.
REQ-027 RSL: in1=0x91 with in2=0..7 -> result 0x91,0x23,0x46,0x8C,0x19,0x32,0x64,0xC8; in2=0x08 -> 0x91 (upper bits ignored).
REQ-028 Reserved ops 101/110/111 with in1=0x91 -> result=0xFF, zero=0; pull rst_n low between edges -> result=0x00, zero=0 immediately.
